// File: rtl/ula_controlador.sv
// ula_controlador: valid/ready command front-end for the 2-bit ALU `ula`.
// Commands are queued in a FIFO, issued one at a time to the ALU, and each
// 3-bit result is held on a valid/ready result port until accepted.
// Optional feature: define ULA_CTRL_ACC_EN to add the cmd_acc port and a
// 2-bit accumulator that can replace operand A for operation chaining.
module ula_controlador #(
  parameter int PROFUNDIDADE = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [3:0]                      cmd_sel,
  input  logic [1:0]                      cmd_a,
  input  logic                            cmd_b,
`ifdef ULA_CTRL_ACC_EN
  input  logic                            cmd_acc,
`endif
  output logic [3:0]                      ula_sel,
  output logic [1:0]                      ula_a,
  output logic                            ula_b,
  input  logic [2:0]                      ula_saida,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [2:0]                      res_dado,
  output logic [3:0]                      res_sel,
  output logic                            res_erro,
  output logic [$clog2(PROFUNDIDADE):0]   nivel
);

  localparam int AW = $clog2(PROFUNDIDADE);
  localparam int NW = AW + 1;

  typedef enum logic [1:0] {OCIOSO, EMITE, ENTREGA} estado_t;

  estado_t         estado;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [3:0]      mem_sel [PROFUNDIDADE];
  logic [1:0]      mem_a   [PROFUNDIDADE];
  logic            mem_b   [PROFUNDIDADE];
  logic            push;
  logic            pop;
  logic            erro;
  logic [1:0]      prox_a;

  assign cmd_ready = (nivel != NW'(PROFUNDIDADE));
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (nivel != '0) &&
                     ((estado == OCIOSO) || ((estado == ENTREGA) && res_ready));
  assign erro      = (ula_sel == 4'b0011) && (ula_b == 1'b0);

`ifdef ULA_CTRL_ACC_EN
  logic       mem_acc [PROFUNDIDADE];
  logic [1:0] acc;

  // Storage for the accumulator-select flag of each queued entry
  always_ff @(posedge clk) begin
    if (push) mem_acc[wr_ptr] <= cmd_acc;
  end

  // On a back-to-back pop in ENTREGA the accumulator is being loaded on the
  // same edge, so the value it is about to receive (res_dado) is used directly.
  always_comb begin
    prox_a = mem_a[rd_ptr];
    if (mem_acc[rd_ptr]) prox_a = (estado == ENTREGA) ? res_dado[1:0] : acc;
  end
`else
  // Operand A always comes from the queued entry
  always_comb begin
    prox_a = mem_a[rd_ptr];
  end
`endif

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push) begin
      mem_sel[wr_ptr] <= cmd_sel;
      mem_a[wr_ptr]   <= cmd_a;
      mem_b[wr_ptr]   <= cmd_b;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      nivel  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   nivel <= nivel + 1'b1;
        2'b01:   nivel <= nivel - 1'b1;
        default: nivel <= nivel;
      endcase
    end
  end

  // Issue/capture/deliver FSM with registered ALU and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      estado    <= OCIOSO;
      ula_sel   <= '0;
      ula_a     <= '0;
      ula_b     <= 1'b0;
      res_valid <= 1'b0;
      res_dado  <= '0;
      res_sel   <= '0;
      res_erro  <= 1'b0;
`ifdef ULA_CTRL_ACC_EN
      acc       <= '0;
`endif
    end else begin
      case (estado)
        OCIOSO: begin
          if (pop) begin
            ula_sel <= mem_sel[rd_ptr];
            ula_a   <= prox_a;
            ula_b   <= mem_b[rd_ptr];
            estado  <= EMITE;
          end
        end
        EMITE: begin
          res_dado  <= erro ? 3'b000 : ula_saida;
          res_sel   <= ula_sel;
          res_erro  <= erro;
          res_valid <= 1'b1;
          estado    <= ENTREGA;
        end
        ENTREGA: begin
          if (res_ready) begin
            res_valid <= 1'b0;
`ifdef ULA_CTRL_ACC_EN
            acc       <= res_dado[1:0];
`endif
            if (pop) begin
              ula_sel <= mem_sel[rd_ptr];
              ula_a   <= prox_a;
              ula_b   <= mem_b[rd_ptr];
              estado  <= EMITE;
            end else begin
              estado  <= OCIOSO;
            end
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule
